// File: rtl/instr_reg_arbiter.sv
// ----------------------------------------------------------------------------
// instr_register_pkg
//   Shared types for instr_register and the agents that drive it.
//
// instr_reg_arbiter
//   Shares one instr_register between two requesters using round-robin
//   arbitration. Each granted request is written at an auto-incrementing
//   address and read back from the same address one cycle later. The read-back
//   word is returned together with a flag that is set when opcode or operands
//   differ from what was written, so load faults are caught in-line.
//   Only one transaction is in flight: IDLE -> WRITE -> READ -> RESP -> IDLE.
//
// Ports
//   clk, reset            single clock; synchronous active-high reset
//   req_valid/req_ready   per-requester handshake, [1:0]
//   req_opcode/operand_*  per-requester payload, unpacked [2]
//   resp_valid/ready      response handshake; resp_* held until accepted
//   resp_id/addr/word     requester index, address written, word read back
//   resp_mismatch         read-back opc/op_a/op_b differ from the request
//   full                  no-wrap mode only: the last entry has been written
//   txn_count             completed responses, saturating at 16'hFFFF
//   reg_*                 drive every input of instr_register;
//                         reg_instruction_word is its read-data output
// ----------------------------------------------------------------------------
package instr_register_pkg;
    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic signed [63:0] result_t;
    typedef logic        [4:0]  address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
        result_t  result;
    } instruction_t;
endpackage

module instr_reg_arbiter
    import instr_register_pkg::*;
#(
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned BASE_ADDR = 0,
    parameter bit          WRAP_EN   = 1'b1
) (
    input  logic               clk,
    input  logic               reset,

    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  opcode_t            req_opcode    [2],
    input  operand_t           req_operand_a [2],
    input  operand_t           req_operand_b [2],

    output logic               resp_valid,
    input  logic               resp_ready,
    output logic               resp_id,
    output address_t           resp_addr,
    output instruction_t       resp_word,
    output logic               resp_mismatch,

    output logic               full,
    output logic [15:0]        txn_count,

    output logic               reg_reset_n,
    output logic               reg_load_en,
    output address_t           reg_write_pointer,
    output address_t           reg_read_pointer,
    output opcode_t            reg_opcode,
    output operand_t           reg_operand_a,
    output operand_t           reg_operand_b,
    input  instruction_t       reg_instruction_word
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam address_t LAST_ADDR  = address_t'(DEPTH - 1);
    localparam address_t FIRST_ADDR = address_t'(BASE_ADDR);

    logic [1:0]   state_q,         state_d;
    address_t     wp_q,            wp_d;
    address_t     rp_q,            rp_d;
    logic         last_grant_q,    last_grant_d;
    logic         lat_id_q,        lat_id_d;
    opcode_t      lat_opc_q,       lat_opc_d;
    operand_t     lat_a_q,         lat_a_d;
    operand_t     lat_b_q,         lat_b_d;
    logic         resp_valid_q,    resp_valid_d;
    logic         resp_id_q,       resp_id_d;
    address_t     resp_addr_q,     resp_addr_d;
    instruction_t resp_word_q,     resp_word_d;
    logic         resp_mismatch_q, resp_mismatch_d;
    logic         full_q,          full_d;
    logic [15:0]  txn_count_q,     txn_count_d;

    logic         grant;
    logic         can_accept;
    logic         in_write;

    // Arbitration: a lone requester always wins; on a tie the requester that
    // was not granted last time wins. last_grant resets to 1 so requester 0
    // takes the first tie.
    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        grant      = 1'b0;
        req_ready  = 2'b00;
        case (req_valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant_q;
            default: grant = 1'b0;
        endcase
        can_accept = (state_q == ST_IDLE) && !full_q && (req_valid != 2'b00);
        if (can_accept) begin
            req_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        state_d         = state_q;
        wp_d            = wp_q;
        rp_d            = rp_q;
        last_grant_d    = last_grant_q;
        lat_id_d        = lat_id_q;
        lat_opc_d       = lat_opc_q;
        lat_a_d         = lat_a_q;
        lat_b_d         = lat_b_q;
        resp_valid_d    = resp_valid_q;
        resp_id_d       = resp_id_q;
        resp_addr_d     = resp_addr_q;
        resp_word_d     = resp_word_q;
        resp_mismatch_d = resp_mismatch_q;
        full_d          = full_q;
        txn_count_d     = txn_count_q;

        case (state_q)
            ST_IDLE: begin
                if (can_accept) begin
                    lat_id_d     = grant;
                    lat_opc_d    = req_opcode[grant];
                    lat_a_d      = req_operand_a[grant];
                    lat_b_d      = req_operand_b[grant];
                    last_grant_d = grant;
                    state_d      = ST_WRITE;
                end
            end

            ST_WRITE: begin
                // Point the read port at the entry being written so it is
                // already addressed throughout READ; it holds afterwards.
                rp_d    = wp_q;
                state_d = ST_READ;
            end

            ST_READ: begin
                resp_word_d     = reg_instruction_word;
                resp_addr_d     = wp_q;
                resp_id_d       = lat_id_q;
                resp_mismatch_d = (reg_instruction_word.opc  != lat_opc_q) ||
                                  (reg_instruction_word.op_a != lat_a_q)   ||
                                  (reg_instruction_word.op_b != lat_b_q);
                resp_valid_d    = 1'b1;
                state_d         = ST_RESP;
                if (wp_q == LAST_ADDR) begin
                    if (WRAP_EN) begin
                        wp_d = FIRST_ADDR;
                    end else begin
                        // Sticky until reset; wp stays on the last entry.
                        full_d = 1'b1;
                    end
                end else begin
                    wp_d = wp_q + address_t'(1);
                end
            end

            ST_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    if (txn_count_q != 16'hFFFF) begin
                        txn_count_d = txn_count_q + 16'd1;
                    end
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            wp_q            <= FIRST_ADDR;
            rp_q            <= '0;
            last_grant_q    <= 1'b1;
            lat_id_q        <= 1'b0;
            lat_opc_q       <= ZERO;
            lat_a_q         <= '0;
            lat_b_q         <= '0;
            resp_valid_q    <= 1'b0;
            resp_id_q       <= 1'b0;
            resp_addr_q     <= '0;
            resp_word_q     <= '0;
            resp_mismatch_q <= 1'b0;
            full_q          <= 1'b0;
            txn_count_q     <= '0;
        end else begin
            state_q         <= state_d;
            wp_q            <= wp_d;
            rp_q            <= rp_d;
            last_grant_q    <= last_grant_d;
            lat_id_q        <= lat_id_d;
            lat_opc_q       <= lat_opc_d;
            lat_a_q         <= lat_a_d;
            lat_b_q         <= lat_b_d;
            resp_valid_q    <= resp_valid_d;
            resp_id_q       <= resp_id_d;
            resp_addr_q     <= resp_addr_d;
            resp_word_q     <= resp_word_d;
            resp_mismatch_q <= resp_mismatch_d;
            full_q          <= full_d;
            txn_count_q     <= txn_count_d;
        end
    end

    // Write-side outputs are only non-zero during WRITE. Gating with reset
    // guarantees a reset that lands on WRITE drops the write.
    assign in_write          = (state_q == ST_WRITE) && !reset;
    assign reg_reset_n       = ~reset;
    assign reg_load_en       = in_write;
    assign reg_write_pointer = in_write ? wp_q      : '0;
    assign reg_opcode        = in_write ? lat_opc_q : ZERO;
    assign reg_operand_a     = in_write ? lat_a_q   : '0;
    assign reg_operand_b     = in_write ? lat_b_q   : '0;
    assign reg_read_pointer  = rp_q;

    assign resp_valid    = resp_valid_q;
    assign resp_id       = resp_id_q;
    assign resp_addr     = resp_addr_q;
    assign resp_word     = resp_word_q;
    assign resp_mismatch = resp_mismatch_q;
    assign full          = full_q;
    assign txn_count     = txn_count_q;

endmodule

// File: tb/tb_instr_reg_arbiter.sv
// ----------------------------------------------------------------------------
// tb_instr_reg_arbiter
//   Directed bench for instr_reg_arbiter. Two instances share every input:
//   w_* has WRAP_EN=1, s_* has WRAP_EN=0. Each instance is backed by a small
//   behavioural instr_register model; force_err makes that model store op_a
//   in place of op_b to emulate a load fault.
// ----------------------------------------------------------------------------
module tb_instr_reg_arbiter;
    import instr_register_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [1:0]   req_valid;
    opcode_t      req_opcode    [2];
    operand_t     req_operand_a [2];
    operand_t     req_operand_b [2];
    logic         resp_ready;
    bit           force_err;

    logic [1:0]   w_req_ready,       s_req_ready;
    logic         w_resp_valid,      s_resp_valid;
    logic         w_resp_id,         s_resp_id;
    address_t     w_resp_addr,       s_resp_addr;
    instruction_t w_resp_word,       s_resp_word;
    logic         w_resp_mismatch,   s_resp_mismatch;
    logic         w_full,            s_full;
    logic [15:0]  w_txn_count,       s_txn_count;
    logic         w_reg_reset_n,     s_reg_reset_n;
    logic         w_reg_load_en,     s_reg_load_en;
    address_t     w_reg_write_pointer, s_reg_write_pointer;
    address_t     w_reg_read_pointer,  s_reg_read_pointer;
    opcode_t      w_reg_opcode,      s_reg_opcode;
    operand_t     w_reg_operand_a,   s_reg_operand_a;
    operand_t     w_reg_operand_b,   s_reg_operand_b;
    instruction_t w_reg_word,        s_reg_word;

    instr_reg_arbiter #(.DEPTH(32), .BASE_ADDR(0), .WRAP_EN(1'b1)) dut_w (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(w_req_ready),
        .req_opcode(req_opcode), .req_operand_a(req_operand_a), .req_operand_b(req_operand_b),
        .resp_valid(w_resp_valid), .resp_ready(resp_ready), .resp_id(w_resp_id),
        .resp_addr(w_resp_addr), .resp_word(w_resp_word), .resp_mismatch(w_resp_mismatch),
        .full(w_full), .txn_count(w_txn_count),
        .reg_reset_n(w_reg_reset_n), .reg_load_en(w_reg_load_en),
        .reg_write_pointer(w_reg_write_pointer), .reg_read_pointer(w_reg_read_pointer),
        .reg_opcode(w_reg_opcode), .reg_operand_a(w_reg_operand_a), .reg_operand_b(w_reg_operand_b),
        .reg_instruction_word(w_reg_word)
    );

    instr_reg_arbiter #(.DEPTH(32), .BASE_ADDR(0), .WRAP_EN(1'b0)) dut_s (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(s_req_ready),
        .req_opcode(req_opcode), .req_operand_a(req_operand_a), .req_operand_b(req_operand_b),
        .resp_valid(s_resp_valid), .resp_ready(resp_ready), .resp_id(s_resp_id),
        .resp_addr(s_resp_addr), .resp_word(s_resp_word), .resp_mismatch(s_resp_mismatch),
        .full(s_full), .txn_count(s_txn_count),
        .reg_reset_n(s_reg_reset_n), .reg_load_en(s_reg_load_en),
        .reg_write_pointer(s_reg_write_pointer), .reg_read_pointer(s_reg_read_pointer),
        .reg_opcode(s_reg_opcode), .reg_operand_a(s_reg_operand_a), .reg_operand_b(s_reg_operand_b),
        .reg_instruction_word(s_reg_word)
    );

    // ---------------- instr_register models ----------------
    function automatic instruction_t model_store(opcode_t opc, operand_t a, operand_t b, bit err);
        instruction_t iw;
        operand_t     bb;
        bb        = err ? a : b;
        iw.opc    = opc;
        iw.op_a   = a;
        iw.op_b   = bb;
        case (opc)
            PASSA:   iw.result = result_t'(a);
            PASSB:   iw.result = result_t'(bb);
            ADD:     iw.result = result_t'(a) + result_t'(bb);
            SUB:     iw.result = result_t'(a) - result_t'(bb);
            MULT:    iw.result = result_t'(a) * result_t'(bb);
            DIV:     iw.result = (bb == 0) ? '0 : result_t'(a / bb);
            MOD:     iw.result = (bb == 0) ? '0 : result_t'(a % bb);
            default: iw.result = '0;
        endcase
        return iw;
    endfunction

    instruction_t mem_w [32];
    instruction_t mem_s [32];

    always @(posedge clk) begin
        if (w_reg_reset_n && w_reg_load_en)
            mem_w[w_reg_write_pointer] <= model_store(w_reg_opcode, w_reg_operand_a, w_reg_operand_b, force_err);
        if (s_reg_reset_n && s_reg_load_en)
            mem_s[s_reg_write_pointer] <= model_store(s_reg_opcode, s_reg_operand_a, s_reg_operand_b, force_err);
    end

    assign w_reg_word = mem_w[w_reg_read_pointer];
    assign s_reg_word = mem_s[s_reg_read_pointer];

    // ---------------- checking ----------------
    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_dut();
        reset     = 1'b1;
        req_valid = 2'b00;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    // One transaction on the wrapping instance. Caller loads the payload for
    // the requesters in mask; the task checks grant, the WRITE and READ
    // cycles, and the response, optionally stalling resp_ready.
    task automatic run_txn(input logic [1:0] mask, input logic exp_id, input int exp_addr,
                           input result_t exp_res, input logic exp_mm, input int stall,
                           input string tag);
        logic [1:0] exp_rdy;
        int         n;
        exp_rdy    = exp_id ? 2'b10 : 2'b01;
        resp_ready = (stall == 0);
        req_valid  = mask;
        #1;
        n = 0;
        while (w_req_ready == 2'b00 && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_grant"}, 64'(w_req_ready), 64'(exp_rdy));
        if (w_req_ready == 2'b00) begin
            req_valid = 2'b00;
            return;
        end
        tick();                                   // handshake edge
        req_valid = 2'b00;
        #1;
        check({tag, "_load_en"}, 64'(w_reg_load_en), 64'd1);
        check({tag, "_wr_ptr"},  64'(w_reg_write_pointer), 64'(exp_addr));
        tick();                                   // load edge -> READ
        check({tag, "_load_off"}, 64'(w_reg_load_en), 64'd0);
        check({tag, "_rd_ptr"},   64'(w_reg_read_pointer), 64'(exp_addr));
        check({tag, "_early_v"},  64'(w_resp_valid), 64'd0);
        tick();                                   // capture edge -> RESP
        check({tag, "_resp_v"},  64'(w_resp_valid), 64'd1);
        check({tag, "_id"},      64'(w_resp_id), 64'(exp_id));
        check({tag, "_addr"},    64'(w_resp_addr), 64'(exp_addr));
        check({tag, "_result"},  64'(w_resp_word.result), 64'(exp_res));
        check({tag, "_mm"},      64'(w_resp_mismatch), 64'(exp_mm));
        if (stall > 0) begin
            req_valid = 2'b10;
            for (int k = 0; k < stall; k++) begin
                tick();
                check({tag, "_hold_v"},      64'(w_resp_valid), 64'd1);
                check({tag, "_hold_addr"},   64'(w_resp_addr), 64'(exp_addr));
                check({tag, "_hold_result"}, 64'(w_resp_word.result), 64'(exp_res));
                check({tag, "_hold_ready"},  64'(w_req_ready), 64'd0);
            end
            req_valid  = 2'b00;
            resp_ready = 1'b1;
        end
        tick();                                   // response handshake edge
        check({tag, "_resp_done"}, 64'(w_resp_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        req_valid  = 2'b00;
        resp_ready = 1'b1;
        force_err  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_opcode[i]    = ZERO;
            req_operand_a[i] = '0;
            req_operand_b[i] = '0;
        end

        // Reset state
        tick();
        tick();
        check("rst_reg_reset_n", 64'(w_reg_reset_n), 64'd0);
        check("rst_resp_valid",  64'(w_resp_valid), 64'd0);
        check("rst_txn_count",   64'(w_txn_count), 64'd0);
        check("rst_full",        64'(s_full), 64'd0);
        check("rst_load_en",     64'(w_reg_load_en), 64'd0);
        check("rst_rd_ptr",      64'(w_reg_read_pointer), 64'd0);
        check("rst_resp_word",   64'(w_resp_word.result), 64'd0);
        reset = 1'b0;
        #1;
        check("rel_reg_reset_n", 64'(w_reg_reset_n), 64'd1);
        check("idle_no_valid",   64'(w_req_ready), 64'd0);

        // Single ADD from requester 0
        req_opcode[0] = ADD; req_operand_a[0] = 5; req_operand_b[0] = 3;
        run_txn(2'b01, 1'b0, 0, 64'sd8, 1'b0, 0, "add");
        check("add_txn_count", 64'(w_txn_count), 64'd1);

        // Both valid from reset: requester 0 first, then alternate
        reset_dut();
        req_opcode[0] = SUB;  req_operand_a[0] = 9; req_operand_b[0] = 4;
        req_opcode[1] = MULT; req_operand_a[1] = 6; req_operand_b[1] = 7;
        run_txn(2'b11, 1'b0, 0, 64'sd5,  1'b0, 0, "rr0");
        run_txn(2'b11, 1'b1, 1, 64'sd42, 1'b0, 0, "rr1");
        run_txn(2'b11, 1'b0, 2, 64'sd5,  1'b0, 0, "rr2");
        run_txn(2'b11, 1'b1, 3, 64'sd42, 1'b0, 0, "rr3");

        // Divide by zero, then MOD with a stalled response
        req_opcode[1] = DIV; req_operand_a[1] = 10; req_operand_b[1] = 0;
        run_txn(2'b10, 1'b1, 4, 64'sd0, 1'b0, 0, "div0");
        req_opcode[1] = MOD; req_operand_a[1] = 10; req_operand_b[1] = 3;
        run_txn(2'b10, 1'b1, 5, 64'sd1, 1'b0, 5, "mod_stall");
        check("stall_txn_count", 64'(w_txn_count), 64'd6);

        // 33 transactions: wrap on one instance, full on the other
        reset_dut();
        for (int i = 0; i < 33; i++) begin
            req_opcode[0] = ADD; req_operand_a[0] = i; req_operand_b[0] = 1;
            run_txn(2'b01, 1'b0, i % 32, result_t'(i + 1), 1'b0, 0, $sformatf("wrap%0d", i));
            if (i == 30) check("full_before_last", 64'(s_full), 64'd0);
            if (i == 31) begin
                check("full_after_32",  64'(s_full), 64'd1);
                check("wrap_not_full",  64'(w_full), 64'd0);
                check("full_count_32",  64'(s_txn_count), 64'd32);
            end
        end
        check("wrap_count_33",  64'(w_txn_count), 64'd33);
        check("full_count_hold", 64'(s_txn_count), 64'd32);
        req_valid = 2'b01;
        #1;
        check("full_no_ready", 64'(s_req_ready), 64'd0);
        check("wrap_ready",    64'(w_req_ready), 64'd1);
        req_valid = 2'b00;

        // Reset during READ aborts the transaction and rewinds wp
        reset_dut();
        req_opcode[0] = ADD; req_operand_a[0] = 1; req_operand_b[0] = 1;
        run_txn(2'b01, 1'b0, 0, 64'sd2, 1'b0, 0, "pre_abort");
        req_opcode[0] = ADD; req_operand_a[0] = 2; req_operand_b[0] = 2;
        req_valid = 2'b01;
        #1;
        tick();                                   // handshake
        req_valid = 2'b00;
        tick();                                   // now in READ
        check("abort_rd_ptr", 64'(w_reg_read_pointer), 64'd1);
        reset = 1'b1;
        tick();
        check("abort_resp_valid", 64'(w_resp_valid), 64'd0);
        check("abort_txn_count",  64'(w_txn_count), 64'd0);
        check("abort_load_en",    64'(w_reg_load_en), 64'd0);
        reset = 1'b0;
        #1;
        req_opcode[0] = SUB; req_operand_a[0] = 7; req_operand_b[0] = 2;
        run_txn(2'b01, 1'b0, 0, 64'sd5, 1'b0, 0, "post_abort");

        // Emulated load fault: op_b read back as op_a
        reset_dut();
        force_err = 1'b1;
        req_opcode[0] = PASSA; req_operand_a[0] = 2; req_operand_b[0] = 7;
        run_txn(2'b01, 1'b0, 0, 64'sd2, 1'b1, 0, "load_fault");
        check("load_fault_op_b", 64'(w_resp_word.op_b), 64'd2);
        force_err = 1'b0;
        req_opcode[0] = PASSB; req_operand_a[0] = 2; req_operand_b[0] = 7;
        run_txn(2'b01, 1'b0, 1, 64'sd7, 1'b0, 0, "load_ok");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
